// File: rtl/usb_sample_buffer_pkg.sv
// Shared constants for the USB sample buffer: how the received word is split
// into stereo fields, the two playback states, and the sample width.
package usb_sample_buffer_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int WORD_W    = 32;

  localparam int LEFT_MSB  = 31;
  localparam int LEFT_LSB  = 16;
  localparam int RIGHT_MSB = 15;
  localparam int RIGHT_LSB = 0;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_PLAY  = 1'b1
  } state_e;

endpackage : usb_sample_buffer_pkg

// File: rtl/sample_fifo_ram.sv
// Simple dual-port storage for the sample FIFO: one synchronous write port and
// one read port with a registered output. No reset and no control logic, so it
// maps directly onto block RAM.
module sample_fifo_ram
  import usb_sample_buffer_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Write on the write strobe; capture the addressed word on the read strobe.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : sample_fifo_ram

// File: rtl/usb_sample_buffer.sv
// Buffers stereo PCM words from the USB FIFO bridge and hands one left/right
// pair to the S/PDIF encoder per sample request. Playback starts only after
// PREFILL words are stored; an empty FIFO in playback yields silence, counts an
// underrun and returns to priming. Every request is answered exactly two
// cycles later, whether with data or with silence.
//
// Handshakes: rx_ce is a one-cycle strobe that is always honoured (rx_en is
// advisory and keeps one slot free for a word already in flight); a word that
// arrives while full is dropped and sets the sticky overflow flag. sample_req
// is a one-cycle strobe; sample_stb pulses for one cycle two cycles later with
// sample_l/sample_r/sample_valid updated in that same cycle.
module usb_sample_buffer
  import usb_sample_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int PREFILL    = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     rx,
  output logic                  rx_en,
  input  logic                  rx_ce,
  input  logic                  sample_req,
  output logic [SAMPLE_W-1:0]   sample_l,
  output logic [SAMPLE_W-1:0]   sample_r,
  output logic                  sample_stb,
  output logic                  sample_valid,
  output logic                  playing,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           underruns,
  output logic                  overflow
);

  localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   PREFILL_L  = (DEPTH_LOG2+1)'(PREFILL);
  localparam logic [DEPTH_LOG2:0]   RX_EN_MAX  = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 2);

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic                    rx_en_q;
  logic                    resp_q;       // a request answer is due next cycle
  logic                    resp_data_q;  // that answer carries FIFO data
  logic [SAMPLE_W-1:0]     sample_l_q, sample_r_q;
  logic                    sample_stb_q, sample_valid_q;
  logic [15:0]             underruns_q;
  logic                    overflow_q;

  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    underrun;
  logic [WORD_W-1:0]       ram_rd_data;

  // Full exactly when the level counter reaches the depth (its top bit).
  assign full = level_q[DEPTH_LOG2];
  assign push = rx_ce && !full;

  // Next-state and pop/underrun decisions for the prime/play controller.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    underrun = 1'b0;
    case (state_q)
      ST_PRIME: begin
        if (level_q >= PREFILL_L) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (sample_req) begin
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            underrun = 1'b1;
            state_d  = ST_PRIME;
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  // Level moves only when exactly one of push/pop happens.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO pointers, level, flow-control flag, overflow and underrun tracking.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rx_en_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underruns_q <= '0;
    end else begin
      level_q <= level_d;
      rx_en_q <= (level_q <= RX_EN_MAX);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (rx_ce && full) begin
        overflow_q <= 1'b1;
      end
      if (underrun && (underruns_q != 16'hFFFF)) begin
        underruns_q <= underruns_q + 16'd1;
      end
    end
  end

  // Two-stage answer path: the decision is registered alongside the RAM read,
  // then the output registers load data or silence.
  always_ff @(posedge clock) begin
    if (!reset) begin
      resp_q         <= 1'b0;
      resp_data_q    <= 1'b0;
      sample_stb_q   <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
    end else begin
      resp_q       <= sample_req;
      resp_data_q  <= pop;
      sample_stb_q <= resp_q;
      if (resp_q) begin
        sample_valid_q <= resp_data_q;
        sample_l_q     <= resp_data_q ? ram_rd_data[LEFT_MSB:LEFT_LSB]   : '0;
        sample_r_q     <= resp_data_q ? ram_rd_data[RIGHT_MSB:RIGHT_LSB] : '0;
      end
    end
  end

  sample_fifo_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (WORD_W)
  ) u_ram (
    .clk_i     (clock),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (rx),
    .rd_en_i   (pop),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rd_data)
  );

  assign rx_en        = rx_en_q;
  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_stb   = sample_stb_q;
  assign sample_valid = sample_valid_q;
  assign playing      = (state_q == ST_PLAY);
  assign level        = level_q;
  assign underruns    = underruns_q;
  assign overflow     = overflow_q;

endmodule : usb_sample_buffer

// File: tb/tb_usb_sample_buffer.sv
// Bench for usb_sample_buffer with an 8-deep FIFO and a prefill of 4.
// A queue-based model tracks stored words, play/prime status and the answer
// due two cycles after each request; a compare process checks every cycle, and
// directed sequences add hand-computed literal checks.
module tb_usb_sample_buffer;

  localparam int DL2   = 3;
  localparam int PF    = 4;
  localparam int DEPTH = 1 << DL2;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rx = '0;
  logic        rx_ce = 1'b0;
  logic        sample_req = 1'b0;
  logic        rx_en;
  logic [15:0] sample_l, sample_r;
  logic        sample_stb, sample_valid, playing, overflow;
  logic [DL2:0] level;
  logic [15:0] underruns;

  always #5 clock = ~clock;

  usb_sample_buffer #(.DEPTH_LOG2(DL2), .PREFILL(PF)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .rx_en        (rx_en),
    .rx_ce        (rx_ce),
    .sample_req   (sample_req),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_stb   (sample_stb),
    .sample_valid (sample_valid),
    .playing      (playing),
    .level        (level),
    .underruns    (underruns),
    .overflow     (overflow)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] exp_q[$];      // words stored, oldest first
  bit          m_play, m_rx_en, m_ovf, m_stb, m_valid;
  logic [15:0] m_l, m_r, m_und;
  bit          p_req, p_valid; // answer owed next edge
  logic [31:0] p_word;
  int          m_sz;
  bit          m_next_play;

  always @(posedge clock) begin
    if (!reset) begin
      exp_q.delete();
      m_play = 0; m_rx_en = 0; m_ovf = 0; m_stb = 0; m_valid = 0;
      m_l = '0; m_r = '0; m_und = '0;
      p_req = 0; p_valid = 0; p_word = '0;
    end else begin
      m_sz = exp_q.size();
      // deliver what was decided on the previous edge
      m_stb = p_req;
      if (p_req) begin
        m_valid = p_valid;
        m_l     = p_word[31:16];
        m_r     = p_word[15:0];
      end
      // decide the answer to this cycle's request
      p_req = sample_req; p_valid = 0; p_word = '0;
      m_next_play = m_play;
      if (sample_req && m_play) begin
        if (m_sz > 0) begin
          p_valid = 1;
          p_word  = exp_q.pop_front();
        end else begin
          if (m_und != 16'hFFFF) m_und = m_und + 16'd1;
          m_next_play = 0;
        end
      end else if (!m_play && m_sz >= PF) begin
        m_next_play = 1;
      end
      m_rx_en = (m_sz <= DEPTH - 2);
      if (rx_ce) begin
        if (m_sz < DEPTH) exp_q.push_back(rx);
        else m_ovf = 1;
      end
      m_play = m_next_play;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      chk("level",     32'(level),        32'(exp_q.size()));
      chk("rx_en",     32'(rx_en),        32'(m_rx_en));
      chk("playing",   32'(playing),      32'(m_play));
      chk("stb",       32'(sample_stb),   32'(m_stb));
      chk("valid",     32'(sample_valid), 32'(m_valid));
      chk("left",      32'(sample_l),     32'(m_l));
      chk("right",     32'(sample_r),     32'(m_r));
      chk("underruns", 32'(underruns),    32'(m_und));
      chk("overflow",  32'(overflow),     32'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [31:0] w);
    rx = w; rx_ce = 1'b1;
    @(negedge clock);
    rx_ce = 1'b0;
  endtask

  // returns at the cycle where the answer must be visible
  task automatic req();
    sample_req = 1'b1;
    @(negedge clock);
    sample_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic wait_play(input string name);
    int k = 0;
    while (!playing && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk(name, 32'(playing), 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] l, input logic [15:0] r, input logic v);
    chk({tag, "_stb"},   32'(sample_stb),   32'd1);
    chk({tag, "_l"},     32'(sample_l),     32'(l));
    chk({tag, "_r"},     32'(sample_r),     32'(r));
    chk({tag, "_valid"}, 32'(sample_valid), 32'(v));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequences ----------------
  initial begin
    reset = 1'b0;
    @(posedge clock);
    chk_en = 1'b1;
    cyc(2);
    chk("rst_level",   32'(level),      32'd0);
    chk("rst_rx_en",   32'(rx_en),      32'd0);
    chk("rst_playing", 32'(playing),    32'd0);
    chk("rst_und",     32'(underruns),  32'd0);
    chk("rst_ovf",     32'(overflow),   32'd0);
    chk("rst_stb",     32'(sample_stb), 32'd0);
    reset = 1'b1;
    cyc(1);
    chk("rx_en_after_rst", 32'(rx_en), 32'd1);

    // request while priming: silence, nothing popped
    push(32'hABADBABE);
    push(32'h11112222);
    req();
    chk_out("prime_req", 16'h0000, 16'h0000, 1'b0);
    chk("prime_und",   32'(underruns), 32'd0);
    chk("prime_level", 32'(level),     32'd2);
    cyc(1);

    // reach prefill, playback starts one cycle later
    push(32'h33334444);
    push(32'h55556666);
    chk("prefill_level", 32'(level),   32'd4);
    chk("prefill_prime", 32'(playing), 32'd0);
    cyc(1);
    chk("prefill_play",  32'(playing), 32'd1);

    req();
    chk_out("first_pop", 16'hABAD, 16'hBABE, 1'b1);
    chk("first_pop_level", 32'(level), 32'd3);
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      req();
      cyc(1);
    end
    chk("drained_l",     32'(sample_l), 32'h5555);
    chk("drained_r",     32'(sample_r), 32'h6666);
    chk("drained_level", 32'(level),    32'd0);

    // underrun: drop to prime next cycle, silence two cycles after request
    sample_req = 1'b1;
    @(negedge clock);
    sample_req = 1'b0;
    chk("ur_playing", 32'(playing),   32'd0);
    chk("ur_count",   32'(underruns), 32'd1);
    @(negedge clock);
    chk_out("ur_out", 16'h0000, 16'h0000, 1'b0);
    cyc(1);

    for (int i = 0; i < 4; i++) push(32'hA0000001 + 32'(i));
    wait_play("resume_play");
    req();
    chk_out("resume_pop", 16'hA000, 16'h0001, 1'b1);
    cyc(1);

    // fill to full and overflow
    do_reset();
    for (int i = 0; i < 7; i++) push(32'h01010101 * 32'(i + 1));
    cyc(1);
    chk("full7_rx_en", 32'(rx_en), 32'd0);
    push(32'h08080808);
    chk("full8_level", 32'(level),    32'd8);
    chk("full8_ovf",   32'(overflow), 32'd0);
    push(32'h09090909);
    chk("full9_level", 32'(level),    32'd8);
    chk("full9_ovf",   32'(overflow), 32'd1);
    cyc(2);

    // simultaneous push and pop at level 1
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hC0DE0000 + 32'(i));
    wait_play("sim_play");
    for (int i = 0; i < 3; i++) begin
      req();
      cyc(1);
    end
    chk("sim_level1", 32'(level), 32'd1);
    rx = 32'hBEEF1234; rx_ce = 1'b1; sample_req = 1'b1;
    @(negedge clock);
    rx_ce = 1'b0; sample_req = 1'b0;
    chk("sim_level_kept", 32'(level), 32'd1);
    @(negedge clock);
    chk_out("sim_pop", 16'hC0DE, 16'h0003, 1'b1);
    chk("sim_und", 32'(underruns), 32'd0);
    cyc(1);
    req();
    chk_out("sim_next", 16'hBEEF, 16'h1234, 1'b1);
    cyc(1);

    // reset with a pop in flight at level 5
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h50000000 + 32'(i));
    wait_play("rst_pop_play");
    sample_req = 1'b1;
    @(negedge clock);
    sample_req = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_stb",   32'(sample_stb),   32'd0);
    chk("midrst_level", 32'(level),        32'd0);
    chk("midrst_valid", 32'(sample_valid), 32'd0);
    chk("midrst_l",     32'(sample_l),     32'd0);
    chk("midrst_play",  32'(playing),      32'd0);
    @(negedge clock);
    chk("midrst_stb2",  32'(sample_stb),   32'd0);
    reset = 1'b1;
    cyc(1);
    push(32'hFEEDF00D);
    for (int i = 0; i < 3; i++) push(32'h77770000 + 32'(i));
    wait_play("post_rst_play");
    req();
    chk_out("post_rst_pop", 16'hFEED, 16'hF00D, 1'b1);
    cyc(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_usb_sample_buffer

// File: doc/usb_sample_buffer.md
# usb_sample_buffer

Downstream consumer of the FT245 USB FIFO bridge's 32-bit receive stream. It accepts stereo PCM words from the bridge's `rx`/`rx_en`/`rx_ce` port and buffers them in an on-chip FIFO. It hands one left/right sample pair to the S/PDIF frame encoder per `sample_req`. The block decouples bursty USB delivery from the fixed audio sample rate: it primes before playback and substitutes silence on underrun.

## Interface
- `DEPTH_LOG2`, 9: FIFO depth is 2^DEPTH_LOG2 words.
- `PREFILL`, 256: words required in FIFO before leaving PRIME; range 1..2^DEPTH_LOG2-1.
- `clock`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-low; sampled on `clock`; 0 = reset.
- `rx`  in  32  word from USB bridge; [31:16] left, [15:0] right, two's complement.
- `rx_en`  out  1  buffer can accept words.
- `rx_ce`  in  1  one-cycle strobe: `rx` holds a new word; taken this cycle.
- `sample_req`  in  1  one-cycle strobe from encoder at frame start; min spacing 3 cycles.
- `sample_l`  out  16  left sample.
- `sample_r`  out  16  right sample.
- `sample_stb`  out  1  one-cycle pulse: `sample_l`/`sample_r` updated.
- `sample_valid`  out  1  last update was real data (0 = substituted silence).
- `playing`  out  1  state is PLAY.
- `level`  out  DEPTH_LOG2+1  words currently stored.
- `underruns`  out  16  saturating underrun count.
- `overflow`  out  1  sticky: word dropped because FIFO full.

## Operation
- Two states: PRIME (reset state) and PLAY.
- **PRIME**
  - Words are accepted.
  - `sample_req` yields silence (`sample_l`=`sample_r`=0, `sample_valid`=0, `sample_stb` pulse).
  - No pop; no underrun count.
  - Move to PLAY in the cycle after registered `level` >= PREFILL.
- **PLAY**
  - `sample_req` with `level`>0: pop one word; outputs get [31:16]/[15:0]; `sample_valid`=1.
  - `sample_req` with `level`==0: underrun. Outputs 0, `sample_valid`=0, `underruns` increments (saturates at 16'hFFFF), next state PRIME.
- **Push**
  - On `rx_ce` when `level` < 2^DEPTH_LOG2: word written at the write pointer.
  - On `rx_ce` when full: word discarded and `overflow` set; it clears only on reset.
- **`rx_en`**: registered; high when `level` <= 2^DEPTH_LOG2-2. This leaves one slot for a word already in flight from the bridge. `rx_ce` is honoured regardless of `rx_en`.
- **Simultaneous push and pop**: both occur; `level` unchanged. Pop at `level`==1 with a push in the same cycle is a valid pop, not an underrun.
- **Pointers**: DEPTH_LOG2 bits wide; wrap modulo depth naturally. `level` is an explicit counter, DEPTH_LOG2+1 bits.
- **Reset (`reset`=0)**, including mid-burst or mid-read:
  - Pointers and `level` = 0, state PRIME.
  - `rx_en`=0, `sample_l`/`sample_r`=0, `sample_stb`=0, `sample_valid`=0, `playing`=0, `underruns`=0, `overflow`=0.
  - Any in-flight pop is cancelled (no `sample_stb`).
  - `rx_en` rises the first cycle after reset releases.

## Timing
- Push: `rx_ce` at cycle N → `level` incremented at N+1. `rx_en` reflects it at N+2.
- Pop: `sample_req` at N → RAM read address N, RAM data N+1. Output registers and `sample_stb` at N+2; `level` decremented at N+1.
- Silence or underrun response: same N+2 latency so the encoder sees fixed timing.
- `playing` asserts one cycle after the threshold is met. It drops at N+1 after an underrun request at N.

## Structure
- Shared package/header holds:
  - word field positions (LEFT_MSB=31, LEFT_LSB=16, RIGHT_MSB=15, RIGHT_LSB=0);
  - state encodings ST_PRIME=0, ST_PLAY=1;
  - sample width 16.
- One sub-module, `sample_fifo_ram`: simple dual-port, 32×2^DEPTH_LOG2, synchronous write, registered read. It infers block RAM and carries no control logic.

## Test plan
- Reset, then 4 `rx_ce` words 32'hABADBABE.. with PREFILL=4, DEPTH_LOG2=3 → `level`=4, `playing`=1 next cycle. First `sample_req` → `sample_l`=16'hABAD, `sample_r`=16'hBABE, `sample_valid`=1 two cycles later.
- `sample_req` in PRIME with `level`=2 → `sample_stb` with zeros, `sample_valid`=0, `underruns`=0, `level` still 2.
- Drain to empty in PLAY, one more `sample_req` → zeros, `sample_valid`=0, `underruns`=1, `playing`=0. Refill to 4 → PLAY resumes.
- Push 7 words (depth 8) → `rx_en`=0. An 8th and 9th `rx_ce` → `level`=8, 9th dropped, `overflow`=1.
- Push and `sample_req` in the same cycle at `level`=1 → valid pop of the oldest word, `level` stays 1, no underrun.
- `reset`=0 asserted at `level`=5 during a pop → no `sample_stb`. All outputs at reset values; FEEDF00D pushed after release reads back as 16'hFEED/16'hF00D.
